// File: rtl/tile_ram_pkg.sv
// Shared constants and CPU handshake state type for the tile RAM arbiter.
// Holds default widths, the starvation limit and the cpu_state_t enum.
package tile_ram_pkg;

  localparam int TILE_ADDR_W       = 10;
  localparam int TILE_DATA_W       = 8;
  localparam int TILE_STARVE_LIMIT = 64;

  typedef enum logic {
    IDLE,
    ACK
  } cpu_state_t;

endpackage

// File: rtl/vid_tile_cache.sv
// One-entry tile cache for the video fetch path: tag/valid/data, hit compare,
// RAM fill, CPU write-through, and the vid_data source mux.
// Ports: clk, rst, req/addr (video), ram_rdata (fill), wt_en/wt_addr/wt_data
// (write-through), hit (to arbiter), vid_valid/vid_data (to video).
module vid_tile_cache
  import tile_ram_pkg::*;
#(
  parameter int ADDR_W = TILE_ADDR_W,
  parameter int DATA_W = TILE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              wt_en,
  input  logic [ADDR_W-1:0] wt_addr,
  input  logic [DATA_W-1:0] wt_data,
  output logic              hit,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data
);

  logic [ADDR_W-1:0] tag;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              fill;
  logic              miss;
  logic              wt_hit;

  assign hit    = req && valid && (addr == tag);
  assign miss   = req && !hit;
  assign wt_hit = wt_en && valid && (wt_addr == tag);

  // fill marks the cycle after a miss: RAM data is arriving for the tag
  // that was just installed, and is also passed straight to the video.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag       <= '0;
      valid     <= 1'b0;
      data      <= '0;
      fill      <= 1'b0;
      vid_valid <= 1'b0;
    end else begin
      vid_valid <= req;
      fill      <= miss;
      if (miss) begin
        tag   <= addr;
        valid <= 1'b1;
      end
      // A CPU write to the cached tile beats a fill landing on the same edge.
      if (wt_hit)
        data <= wt_data;
      else if (fill)
        data <= ram_rdata;
    end
  end

  assign vid_data = fill ? ram_rdata : data;

endmodule

// File: rtl/tile_ram_arbiter.sv
// Single-port tile RAM arbiter: video misses own the RAM, CPU requests take
// free slots via a req/ack handshake, and starvation is flagged.
// Ports: video (vid_req/vid_addr -> vid_valid/vid_data), CPU (cpu_req/we/
// addr/wdata -> cpu_ack/rdata/starve), RAM (ram_addr/we/wdata, ram_rdata).
module tile_ram_arbiter
  import tile_ram_pkg::*;
#(
  parameter int ADDR_W       = TILE_ADDR_W,
  parameter int DATA_W       = TILE_DATA_W,
  parameter int STARVE_LIMIT = TILE_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_starve,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  cpu_state_t    state;
  logic [CW-1:0] wait_cnt;
  logic          hit;
  logic          miss;
  logic          grant;
  logic          wr;

  // RAM port stays quiet while reset is held, whatever the requesters do.
  assign miss  = !rst && vid_req && !hit;
  assign grant = !rst && (state == IDLE) && cpu_req && !miss;
  assign wr    = grant && cpu_we;

  vid_tile_cache #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cache (
    .clk       (clk),
    .rst       (rst),
    .req       (vid_req),
    .addr      (vid_addr),
    .ram_rdata (ram_rdata),
    .wt_en     (wr),
    .wt_addr   (cpu_addr),
    .wt_data   (cpu_wdata),
    .hit       (hit),
    .vid_valid (vid_valid),
    .vid_data  (vid_data)
  );

  always_comb begin
    ram_addr = '0;
    if (miss)
      ram_addr = vid_addr;
    else if (grant)
      ram_addr = cpu_addr;
  end

  assign ram_we    = wr;
  assign ram_wdata = wr ? cpu_wdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cpu_ack  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      cpu_ack <= grant;
      unique case (state)
        IDLE: if (grant) state <= ACK;
        ACK:  state <= IDLE;
      endcase
      if (grant)
        wait_cnt <= '0;
      else if (state == IDLE && cpu_req &&
               wait_cnt != CW'(STARVE_LIMIT))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign cpu_rdata  = cpu_ack ? ram_rdata : '0;
  assign cpu_starve = (wait_cnt == CW'(STARVE_LIMIT));

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Self-checking bench for tile_ram_arbiter: vector table, directed corner
// sequences, and randomized traffic against a coherent-memory model.
module tb_tile_ram_arbiter;

  logic       clk;
  logic       rst;
  logic       vid_req;
  logic [9:0] vid_addr;
  logic       vid_valid;
  logic [7:0] vid_data;
  logic       cpu_req;
  logic       cpu_we;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       cpu_starve;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  logic       load;
  logic [7:0] mem [1024];
  logic [7:0] model_mem [1024];

  int n_cmp = 0;
  int n_bad = 0;

  tile_ram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_valid  (vid_valid),
    .vid_data   (vid_data),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .cpu_starve (cpu_starve),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  function automatic logic [7:0] f(int i);
    return 8'(i * 37 + 11);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-before-write.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 1024; i++) mem[i] <= f(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       vreq;
    logic [9:0] vaddr;
    logic       creq;
    logic       cwe;
    logic [9:0] caddr;
    logic [7:0] cwd;
    logic [9:0] e_raddr;
    logic       e_rwe;
    logic [7:0] e_rwd;
    logic       e_vv;
    logic [7:0] e_vd;
    logic       e_ack;
    logic [7:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(logic vreq, logic [9:0] vaddr, logic creq, logic cwe,
                     logic [9:0] caddr, logic [7:0] cwd, logic [9:0] e_raddr,
                     logic e_rwe, logic [7:0] e_rwd, logic e_vv,
                     logic [7:0] e_vd, logic e_ack, logic [7:0] e_rd);
    vec_t v;
    v.vreq = vreq; v.vaddr = vaddr; v.creq = creq; v.cwe = cwe;
    v.caddr = caddr; v.cwd = cwd; v.e_raddr = e_raddr; v.e_rwe = e_rwe;
    v.e_rwd = e_rwd; v.e_vv = e_vv; v.e_vd = e_vd; v.e_ack = e_ack;
    v.e_rd = e_rd;
    tbl.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    logic       seen;
    logic [9:0] last_addr;
    logic       exp_vv;
    logic [9:0] exp_addr;
    logic       busy;
    logic       c_we;
    logic [9:0] c_addr;
    logic [7:0] c_wd;
    logic       cur_vreq;
    logic [9:0] cur_vaddr;
    logic       got_ack;
    logic       miss_m;
    int         wait_cnt;
    int         run_left;

    for (int i = 0; i < 1024; i++) model_mem[i] = f(i);

    // Reset with traffic on both ports: everything must stay at zero.
    rst = 1'b1; load = 1'b1;
    vid_req = 1'b1; vid_addr = 10'h005;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3FF; cpu_wdata = 8'hAA;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    chk("rst_vid_valid", 32'(vid_valid), 0);
    chk("rst_vid_data", 32'(vid_data), 0);
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_cpu_starve", 32'(cpu_starve), 0);
    @(negedge clk);
    rst = 1'b0; load = 1'b0;

    // vreq vaddr creq we caddr wd | raddr we wd vv vd ack rd
    add(1, 10'h005, 0, 0, 10'h000, 8'h00, 10'h005, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    add(1, 10'h021, 1, 1, 10'h100, 8'h7F, 10'h021, 0, 8'h00, 1, f(5), 0, 8'h00);
    add(1, 10'h021, 1, 1, 10'h100, 8'h7F, 10'h100, 1, 8'h7F, 1, f(33), 0, 8'h00);
    add(1, 10'h021, 1, 1, 10'h100, 8'h7F, 10'h000, 0, 8'h00, 1, f(33), 1, 8'h00);
    for (int k = 0; k < 13; k++)
      add(1, 10'h021, 0, 0, 10'h000, 8'h00, 10'h000, 0, 8'h00, 1, f(33), 0, 8'h00);
    add(1, 10'h021, 1, 1, 10'h021, 8'h3C, 10'h021, 1, 8'h3C, 1, f(33), 0, 8'h00);
    add(1, 10'h021, 1, 1, 10'h021, 8'h3C, 10'h000, 0, 8'h00, 1, 8'h3C, 1, 8'h00);
    add(1, 10'h021, 0, 0, 10'h000, 8'h00, 10'h000, 0, 8'h00, 1, 8'h3C, 0, 8'h00);
    add(0, 10'h000, 1, 0, 10'h100, 8'h00, 10'h100, 0, 8'h00, 1, 8'h3C, 0, 8'h00);
    add(0, 10'h000, 1, 0, 10'h100, 8'h00, 10'h000, 0, 8'h00, 0, 8'h00, 1, 8'h7F);
    add(1, 10'h021, 0, 0, 10'h000, 8'h00, 10'h000, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    add(0, 10'h000, 0, 0, 10'h000, 8'h00, 10'h000, 0, 8'h00, 1, 8'h3C, 0, 8'h00);

    for (int k = 0; k < tbl.size(); k++) begin
      v = tbl[k];
      vid_req = v.vreq; vid_addr = v.vaddr;
      cpu_req = v.creq; cpu_we = v.cwe;
      cpu_addr = v.caddr; cpu_wdata = v.cwd;
      #1;
      chk($sformatf("tbl%0d_ram_addr", k), 32'(ram_addr), 32'(v.e_raddr));
      chk($sformatf("tbl%0d_ram_we", k), 32'(ram_we), 32'(v.e_rwe));
      if (v.e_rwe)
        chk($sformatf("tbl%0d_ram_wdata", k), 32'(ram_wdata), 32'(v.e_rwd));
      chk($sformatf("tbl%0d_vid_valid", k), 32'(vid_valid), 32'(v.e_vv));
      if (v.e_vv)
        chk($sformatf("tbl%0d_vid_data", k), 32'(vid_data), 32'(v.e_vd));
      chk($sformatf("tbl%0d_cpu_ack", k), 32'(cpu_ack), 32'(v.e_ack));
      if (v.e_ack && !v.cwe)
        chk($sformatf("tbl%0d_cpu_rdata", k), 32'(cpu_rdata), 32'(v.e_rd));
      @(negedge clk);
    end
    model_mem[10'h100] = 8'h7F;
    model_mem[10'h021] = 8'h3C;

    // Continuous video misses starve a CPU read.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010; cpu_wdata = 8'h00;
    for (int i = 0; i < 70; i++) begin
      vid_req = 1'b1; vid_addr = 10'(i % 2);
      #1;
      chk($sformatf("starve%0d_ram_addr", i), 32'(ram_addr), 32'(vid_addr));
      chk($sformatf("starve%0d_ack", i), 32'(cpu_ack), 0);
      chk($sformatf("starve%0d_flag", i), 32'(cpu_starve), 32'(i >= 64));
      @(negedge clk);
    end
    vid_req = 1'b0;
    #1;
    chk("starve_grant_addr", 32'(ram_addr), 32'h010);
    chk("starve_flag_at_grant", 32'(cpu_starve), 1);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("starve_ack", 32'(cpu_ack), 1);
    chk("starve_rdata", 32'(cpu_rdata), 32'(model_mem[10'h010]));
    chk("starve_flag_clear", 32'(cpu_starve), 0);
    @(negedge clk);

    // cpu_req held high straight through ACK: one ack every 2 cycles.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h021;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("held%0d_ack", i), 32'(cpu_ack), 32'(i % 2));
      chk($sformatf("held%0d_ram_addr", i), 32'(ram_addr),
          (i % 2 == 1) ? 32'h0 : 32'h021);
      if (cpu_ack)
        chk($sformatf("held%0d_rdata", i), 32'(cpu_rdata),
            32'(model_mem[10'h021]));
      @(negedge clk);
    end
    cpu_req = 1'b0;
    @(negedge clk);

    // Reset lands in the cycle after a CPU write grant.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h200; cpu_wdata = 8'h55;
    #1;
    chk("rstmid_grant_we", 32'(ram_we), 1);
    @(negedge clk);
    model_mem[10'h200] = 8'h55;
    rst = 1'b1; cpu_req = 1'b0;
    #1;
    chk("rstmid_no_ack", 32'(cpu_ack), 0);
    @(negedge clk);
    rst = 1'b0; vid_req = 1'b1; vid_addr = 10'h021;
    #1;
    chk("rstmid_miss_addr", 32'(ram_addr), 32'h021);
    chk("rstmid_ack_low", 32'(cpu_ack), 0);
    @(negedge clk);
    vid_req = 1'b0;
    #1;
    chk("rstmid_vid_data", 32'(vid_data), 32'(model_mem[10'h021]));
    chk("rstmid_ack_still_low", 32'(cpu_ack), 0);
    @(negedge clk);

    // Randomized traffic: video sees a coherent memory one cycle later.
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0; last_addr = '0; exp_vv = 1'b0; exp_addr = '0;
    busy = 1'b0; c_we = 1'b0; c_addr = '0; c_wd = '0;
    cur_vreq = 1'b0; cur_vaddr = '0; wait_cnt = 0; run_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      got_ack = cpu_ack;
      if (!busy) begin
        chk("rnd_no_spurious_ack", 32'(cpu_ack), 0);
      end else if (got_ack) begin
        if (c_we)
          model_mem[c_addr] = c_wd;
        else
          chk("rnd_cpu_rdata", 32'(cpu_rdata), 32'(model_mem[c_addr]));
        busy = 1'b0;
      end else begin
        wait_cnt++;
        if (wait_cnt > 500) begin
          n_cmp++; n_bad++;
          $display("FAIL rnd_ack_timeout: got no ack want ack within 500");
          break;
        end
      end
      chk("rnd_vid_valid", 32'(vid_valid), 32'(exp_vv));
      if (exp_vv)
        chk("rnd_vid_data", 32'(vid_data), 32'(model_mem[exp_addr]));

      if (run_left == 0) begin
        cur_vreq = ($urandom_range(0, 3) != 0);
        cur_vaddr = 10'($urandom_range(0, 7));
        run_left = $urandom_range(1, 16);
      end
      run_left--;
      vid_req = cur_vreq; vid_addr = cur_vaddr;
      if (!busy && !got_ack && $urandom_range(0, 2) == 0) begin
        busy = 1'b1;
        c_we = 1'($urandom_range(0, 1));
        c_addr = 10'($urandom_range(0, 7));
        c_wd = 8'($urandom);
        wait_cnt = 0;
      end
      cpu_req = busy; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
      #1;
      miss_m = vid_req && !(seen && vid_addr == last_addr);
      if (miss_m) begin
        chk("rnd_miss_addr", 32'(ram_addr), 32'(vid_addr));
        chk("rnd_miss_we", 32'(ram_we), 0);
      end else if (!busy) begin
        chk("rnd_idle_addr", 32'(ram_addr), 0);
        chk("rnd_idle_we", 32'(ram_we), 0);
      end
      if (vid_req) begin
        seen = 1'b1;
        last_addr = vid_addr;
      end
      exp_vv = vid_req; exp_addr = vid_addr;
      @(negedge clk);
    end

    for (int i = 0; i < 8; i++)
      chk($sformatf("ram_final%0d", i), 32'(mem[i]), 32'(model_mem[i]));
    chk("ram_final_100", 32'(mem[10'h100]), 32'(model_mem[10'h100]));
    chk("ram_final_200", 32'(mem[10'h200]), 32'(model_mem[10'h200]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
